// File: rtl/sdram_ctrl_pkg.sv
// rtl/sdram_ctrl_pkg.sv - shared sdram_ctrl types: default FIFO depth and 16-bit word byte order
package sdram_ctrl_pkg;

  // Default word-address width for the rfifo/wfifo pair (2^8 = 256 words).
  localparam int DEFAULT_ADDR_W = 8;

  // Byte order of a 16-bit FIFO word: lo is transferred first, hi second.
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } fifo_word_t;

  // Which half of a word the read side is positioned on.
  typedef enum logic {
    BYTE_LO = 1'b0,
    BYTE_HI = 1'b1
  } byte_sel_e;

  // Pick one byte out of a word according to the shared byte order.
  function automatic logic [7:0] select_byte(input fifo_word_t word, input byte_sel_e sel);
    return (sel == BYTE_HI) ? word.hi : word.lo;
  endfunction

endpackage

// File: rtl/rfifo_16to8_if.sv
// rtl/rfifo_16to8_if.sv - write/read handshake and status bundle of the 16-to-8 read FIFO
interface rfifo_16to8_if
  import sdram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              fifo_wr_en;
  logic [15:0]       fifo_wr_data;
  logic              fifo_full;
  logic              fifo_rd_en;
  logic [7:0]        fifo_rd_data;
  logic              fifo_rd_valid;
  logic              fifo_empty;
  logic [ADDR_W+1:0] fifo_usedb;
  logic              fifo_wr_err;
  logic              fifo_rd_err;

  // The producer/consumer side: issues requests, observes status.
  modport master (
    output fifo_wr_en,
    output fifo_wr_data,
    output fifo_rd_en,
    input  fifo_full,
    input  fifo_rd_data,
    input  fifo_rd_valid,
    input  fifo_empty,
    input  fifo_usedb,
    input  fifo_wr_err,
    input  fifo_rd_err
  );

  // The FIFO itself.
  modport slave (
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  fifo_rd_en,
    output fifo_full,
    output fifo_rd_data,
    output fifo_rd_valid,
    output fifo_empty,
    output fifo_usedb,
    output fifo_wr_err,
    output fifo_rd_err
  );

endinterface

// File: rtl/ram_sp_16.sv
// rtl/ram_sp_16.sv - 16-bit storage array, synchronous write, asynchronous read
module ram_sp_16 #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset; pointers define what is valid.
  logic [15:0] mem [0:DEPTH-1];

  // Store one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rfifo_16to8.sv
// rtl/rfifo_16to8.sv - single-clock FIFO taking 16-bit words and returning them as bytes
module rfifo_16to8
  import sdram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic         fifo_clk,
  input  logic         rst_n,
  rfifo_16to8_if.slave bus
);

  // Write pointer counts words (MSB is the wrap bit); read pointer counts
  // bytes, so its LSB is the byte select and the bits above are the word pointer.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W+1:0] rd_ptr;

  logic [ADDR_W:0]   rd_word_ptr;
  logic [ADDR_W-1:0] rd_word_idx;
  byte_sel_e         rd_byte_sel;
  logic [ADDR_W:0]   word_diff;

  logic              empty;
  logic              full;
  logic              wr_accept;
  logic              rd_accept;
  logic [15:0]       ram_rdata;
  logic [7:0]        rd_byte;

  assign rd_word_ptr = rd_ptr[ADDR_W+1:1];
  assign rd_word_idx = rd_ptr[ADDR_W:1];
  assign rd_byte_sel = byte_sel_e'(rd_ptr[0]);

  // Empty only on a word boundary: a half-read word still has a byte left.
  assign empty = (wr_ptr == rd_word_ptr) && (rd_byte_sel == BYTE_LO);

  // A half-read word keeps its slot, so fullness compares word pointers only.
  assign full = (wr_ptr[ADDR_W-1:0] == rd_word_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W+1]);

  assign wr_accept = bus.fifo_wr_en && !full;
  assign rd_accept = bus.fifo_rd_en && !empty;

  // Two bytes per unread word, minus the byte already taken from the head word.
  assign word_diff      = wr_ptr - rd_word_ptr;
  assign bus.fifo_usedb = {word_diff, 1'b0} - {{(ADDR_W+1){1'b0}}, rd_ptr[0]};

  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;

  ram_sp_16 #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (fifo_clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (bus.fifo_wr_data),
    .rd_addr (rd_word_idx),
    .rd_data (ram_rdata)
  );

  assign rd_byte = select_byte(fifo_word_t'(ram_rdata), rd_byte_sel);

  // Advance the write pointer by one word on each accepted write.
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
    end
  end

  // Advance the read pointer by one byte on each accepted read.
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_accept) begin
      rd_ptr <= rd_ptr + (ADDR_W+2)'(1);
    end
  end

  // Register the popped byte; hold the previous byte when nothing is popped.
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fifo_rd_data  <= 8'h00;
      bus.fifo_rd_valid <= 1'b0;
    end else begin
      bus.fifo_rd_valid <= rd_accept;
      if (rd_accept) begin
        bus.fifo_rd_data <= rd_byte;
      end
    end
  end

  // Flag rejected requests for exactly one cycle.
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fifo_wr_err <= 1'b0;
      bus.fifo_rd_err <= 1'b0;
    end else begin
      bus.fifo_wr_err <= bus.fifo_wr_en && full;
      bus.fifo_rd_err <= bus.fifo_rd_en && empty;
    end
  end

endmodule

// File: tb/tb_rfifo_16to8.sv
// tb/tb_rfifo_16to8.sv - self-checking bench for rfifo_16to8
module tb_rfifo_16to8;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rfifo_16to8_if #(.ADDR_W(ADDR_W)) bus ();

  rfifo_16to8 #(.ADDR_W(ADDR_W)) dut (
    .fifo_clk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO contents as a plain byte queue.
  logic [7:0] m_q[$];
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_wr_err;
  bit         m_rd_err;
  int         popped;

  typedef struct {
    bit          we;
    logic [15:0] wd;
    bit          re;
    bit          v;
    logic [7:0]  d;
    bit          e;
    bit          f;
    int          u;
    bit          wer;
    bit          rer;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_slots();
    return (m_q.size() + 1) / 2;
  endfunction

  // Apply one cycle of requests, advance the model, land #1 after the edge.
  task automatic cycle(input bit we, input logic [15:0] wd, input bit re);
    bit wr_ok, rd_ok;
    bus.fifo_wr_en   = we;
    bus.fifo_wr_data = wd;
    bus.fifo_rd_en   = re;
    wr_ok    = we && (m_slots() < DEPTH);
    rd_ok    = re && (m_q.size() > 0);
    m_wr_err = we && !wr_ok;
    m_rd_err = re && !rd_ok;
    m_valid  = rd_ok;
    if (rd_ok) begin
      m_data = m_q.pop_front();
      popped++;
    end
    if (wr_ok) begin
      m_q.push_back(wd[7:0]);
      m_q.push_back(wd[15:8]);
    end
    @(posedge clk);
    #1;
    bus.fifo_wr_en = 1'b0;
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(bus.fifo_rd_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(bus.fifo_rd_data),  32'(m_data));
    chk({tag, "_empty"}, 32'(bus.fifo_empty),    32'(m_q.size() == 0));
    chk({tag, "_full"},  32'(bus.fifo_full),     32'(m_slots() == DEPTH));
    chk({tag, "_usedb"}, 32'(bus.fifo_usedb),    32'(m_q.size()));
    chk({tag, "_wr_err"}, 32'(bus.fifo_wr_err),  32'(m_wr_err));
    chk({tag, "_rd_err"}, 32'(bus.fifo_rd_err),  32'(m_rd_err));
  endtask

  // Assert reset away from the clock edge with requests pending; they must be ignored.
  task automatic do_reset();
    bus.fifo_wr_en   = 1'b1;
    bus.fifo_wr_data = 16'hDEAD;
    bus.fifo_rd_en   = 1'b1;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_data   = 8'h00;
    m_valid  = 1'b0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
    check_model("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_model("rst_held");
    bus.fifo_wr_en = 1'b0;
    bus.fifo_rd_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int cyc;
    int wp;
    logic [15:0] w;

    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = 16'h0000;
    bus.fifo_rd_en   = 1'b0;
    m_data  = 8'h00;
    popped  = 0;

    //           we    wd        re    v     d      e     f     u  wer   rer
    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    // Reset state.
    @(negedge clk);
    do_reset();

    // Hand-computed vectors: byte order, latency, empty read, write+read on empty.
    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].wd, vecs[i].re);
      chk($sformatf("vec%0d_valid", i),  32'(bus.fifo_rd_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_data", i),   32'(bus.fifo_rd_data),  32'(vecs[i].d));
      chk($sformatf("vec%0d_empty", i),  32'(bus.fifo_empty),    32'(vecs[i].e));
      chk($sformatf("vec%0d_full", i),   32'(bus.fifo_full),     32'(vecs[i].f));
      chk($sformatf("vec%0d_usedb", i),  32'(bus.fifo_usedb),    32'(vecs[i].u));
      chk($sformatf("vec%0d_wr_err", i), 32'(bus.fifo_wr_err),   32'(vecs[i].wer));
      chk($sformatf("vec%0d_rd_err", i), 32'(bus.fifo_rd_err),   32'(vecs[i].rer));
    end

    // Fill to full, overflow, then free a slot only after both bytes are popped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(i) ^ 8'hFF, 8'(i)};
      cycle(1'b1, w, 1'b0);
      check_model("fill");
    end
    chk("full_at_256", 32'(bus.fifo_full), 32'd1);
    chk("usedb_at_256", 32'(bus.fifo_usedb), 32'd512);
    cycle(1'b1, 16'hFFFF, 1'b0);
    check_model("overflow");
    chk("overflow_err", 32'(bus.fifo_wr_err), 32'd1);
    chk("overflow_usedb", 32'(bus.fifo_usedb), 32'd512);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("wr_err_one_cycle", 32'(bus.fifo_wr_err), 32'd0);
    cycle(1'b0, 16'h0000, 1'b1);
    check_model("half_read");
    chk("half_read_full", 32'(bus.fifo_full), 32'd1);
    chk("half_read_usedb", 32'(bus.fifo_usedb), 32'd511);
    chk("half_read_data", 32'(bus.fifo_rd_data), 32'h00);
    cycle(1'b1, 16'h7777, 1'b1);
    check_model("full_wr_rd");
    chk("full_wr_rd_err", 32'(bus.fifo_wr_err), 32'd1);
    chk("full_wr_rd_data", 32'(bus.fifo_rd_data), 32'hFF);
    chk("slot_freed", 32'(bus.fifo_full), 32'd0);
    chk("slot_freed_usedb", 32'(bus.fifo_usedb), 32'd510);
    cycle(1'b1, 16'h7777, 1'b0);
    check_model("refill");

    // Randomized stream of 1000 incrementing words across many pointer wraps.
    do_reset();
    popped = 0;
    n = 0;
    cyc = 0;
    while (cyc < 20000 && !(n == 1000 && m_q.size() == 0)) begin
      bit we, re;
      bit accepted;
      wp = ((cyc / 300) % 2) ? 85 : 35;
      we = (n < 1000) && ($urandom_range(0, 99) < wp);
      re = ($urandom_range(0, 99) < (120 - wp));
      accepted = we && (m_slots() < DEPTH);
      cycle(we, 16'h1000 + 16'(n), re);
      if (accepted) n++;
      check_model("stream");
      cyc++;
    end
    chk("stream_words", 32'(n), 32'd1000);
    chk("stream_bytes", 32'(popped), 32'd2000);

    // Reset mid-stream with 10 words stored; only new data comes out afterwards.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h2000 + 16'(i), 1'b0);
    end
    check_model("pre_rst");
    do_reset();
    cycle(1'b1, 16'hBEEF, 1'b1);
    check_model("post_rst_wr");
    cycle(1'b0, 16'h0000, 1'b1);
    check_model("post_rst_rd0");
    chk("post_rst_byte0", 32'(bus.fifo_rd_data), 32'hEF);
    cycle(1'b0, 16'h0000, 1'b1);
    check_model("post_rst_rd1");
    chk("post_rst_byte1", 32'(bus.fifo_rd_data), 32'hBE);
    cycle(1'b0, 16'h0000, 1'b1);
    check_model("post_rst_empty");
    chk("post_rst_rd_err", 32'(bus.fifo_rd_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfifo_16to8.md
RFIFO_16TO8 -- requirements
Module: rfifo_16to8

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; storage depth = 2^ADDR_W 16-bit words.
REQ-002 fifo_clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 fifo_wr_en  input  1  write request, one 16-bit word per cycle.
REQ-005 fifo_wr_data  input  16  write word; [7:0] is the first byte out, [15:8] the second.
REQ-006 fifo_full  output  1  no free word slot.
REQ-007 fifo_rd_en  input  1  read request, one byte per cycle.
REQ-008 fifo_rd_data  output  8  registered read byte.
REQ-009 fifo_rd_valid  output  1  fifo_rd_data holds a newly popped byte this cycle.
REQ-010 fifo_empty  output  1  no unread byte.
REQ-011 fifo_usedb  output  ADDR_W+2  unread byte count, 0..2^(ADDR_W+1).
REQ-012 fifo_wr_err  output  1  one-cycle pulse: write attempted while full.
REQ-013 fifo_rd_err  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-014 Write pointer SHALL be ADDR_W+1 bits binary (MSB = wrap bit); read pointer SHALL be ADDR_W+2 bits binary: word index, wrap bit and byte-select LSB.
REQ-015 Write accepted iff fifo_wr_en && !fifo_full; it stores the word at wr_ptr[ADDR_W-1:0] and increments wr_ptr, wrapping modulo 2^(ADDR_W+1).
REQ-016 Read accepted iff fifo_rd_en && !fifo_empty; it increments rd_ptr by one byte.
REQ-017 Read latency SHALL be 1 cycle: the byte of an accepted read appears on fifo_rd_data, with fifo_rd_valid=1, on the next cycle.
REQ-018 Byte selection: rd_ptr LSB=0 selects word[7:0]; LSB=1 selects word[15:8].
REQ-019 fifo_rd_data SHALL hold its last value when no read is accepted; fifo_rd_valid=0 in that cycle.
REQ-020 fifo_empty = (wr_ptr == rd_ptr[ADDR_W+1:1]) && (rd_ptr LSB == 0), combinational from registered pointers.
REQ-021 fifo_full = (wr_ptr[ADDR_W-1:0] == rd_ptr word index) && (wrap bits differ). A half-read word still occupies its slot.
REQ-022 fifo_usedb = 2*(wr_ptr - rd_ptr word part) - rd_ptr LSB, computed modulo ADDR_W+2 bits.
REQ-023 Simultaneous write and read SHALL both be accepted when neither is blocked.
REQ-024 A write to an empty FIFO SHALL NOT be readable in the same cycle; fifo_empty deasserts the next cycle.
REQ-025 While full, a write is rejected even if a read is accepted in the same cycle; the slot frees only after the second byte of the oldest word is popped.
REQ-026 A rejected write SHALL set fifo_wr_err for one cycle, with storage and pointers unchanged. A rejected read SHALL set fifo_rd_err for one cycle, with pointer and data unchanged.
REQ-027 Pointer wrap-around SHALL be seamless; no data loss or duplication across the 2^ADDR_W boundary.

Reset
REQ-028 On rst_n low, immediately: wr_ptr=0, rd_ptr=0, fifo_rd_data=8'h00, fifo_rd_valid=0, fifo_wr_err=0, fifo_rd_err=0; hence fifo_empty=1, fifo_full=0, fifo_usedb=0.
REQ-029 Storage array contents are not reset; stored data is discarded on reset mid-operation.
REQ-030 Requests during reset SHALL be ignored; operation resumes on the first rising edge after rst_n deasserts.

Structure
REQ-031 Default ADDR_W and the byte-order definition SHALL live in the shared sdram_ctrl package, which wfifo-side code also uses.
REQ-032 Storage SHALL be a single sub-module, ram_sp_16 (16-bit, 2^ADDR_W deep, synchronous write, asynchronous read); pointer and flag logic stays in rfifo_16to8.

Verification
REQ-033 Reset, write 16'hA55A, then read twice -> bytes 8'h5A then 8'hA5, each with fifo_rd_valid one cycle after its accepted read; fifo_empty=1 afterwards.
REQ-034 With ADDR_W=8, write 256 words -> fifo_full=1 and fifo_usedb=512; 257th write -> fifo_wr_err pulse, no change.
REQ-035 From full, read 1 byte -> fifo_full stays 1 and fifo_usedb=511; read a 2nd byte -> fifo_full=0.
REQ-036 From empty, read -> fifo_rd_err pulse and fifo_rd_data unchanged; write and read in the same cycle -> read rejected, write stored.
REQ-037 Stream 1000 incrementing words with random wr_en/rd_en -> output bytes in exact order across pointer wrap, fifo_usedb always matching the model.
REQ-038 Assert rst_n low mid-stream with 10 words stored -> fifo_empty=1 and fifo_usedb=0 immediately; the next write/read pair returns only new data.
